// File: rtl/lw_sha_pkg.sv
// Shared SHA digest types, word rotate helpers and reader FSM encoding.
// LW_SHA_DIGEST_ZEROIZE_EN selects slot zeroization in the reader.
package lw_sha_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ROT_W     = $clog2(WORD_SIZE);

  typedef logic [WORD_SIZE-1:0] word_t;
  typedef logic [ROT_W-1:0]     rot_t;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t ST_IDLE   = 1'b0;
  localparam rd_state_t ST_STREAM = 1'b1;

  // Doubling the word keeps rot=0 an identity without a full-width shift.
  function automatic word_t rol(input word_t w, input rot_t r);
    logic [2*WORD_SIZE-1:0] d;
    d = {w, w} << r;
    return d[2*WORD_SIZE-1:WORD_SIZE];
  endfunction

  function automatic word_t ror(input word_t w, input rot_t r);
    logic [2*WORD_SIZE-1:0] d;
    d = {w, w} >> r;
    return d[WORD_SIZE-1:0];
  endfunction

endpackage

// File: rtl/lw_sha_word_unmask.sv
// Combinational unmask of one digest slot: rol(word, rot).
// Used by lw_sha_digest_reader.
module lw_sha_word_unmask
  import lw_sha_pkg::*;
#(
  parameter int W  = WORD_SIZE,
  parameter int RW = ROT_W
) (
  input  logic [W-1:0]  word_i,
  input  logic [RW-1:0] rot_i,
  output logic [W-1:0]  word_o
);

  logic [2*W-1:0] dbl;

  always_comb begin
    dbl    = {word_i, word_i} << rot_i;
    word_o = dbl[2*W-1:W];
  end

endmodule

// File: rtl/lw_sha_digest_reader.sv
// Streams masked SHA state words out unmasked over a valid/ready port.
// Define LW_SHA_DIGEST_ZEROIZE_EN to scrub slots with rnd_i as they drain.
module lw_sha_digest_reader #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_WORDS = 8,
  parameter int ROT_W     = $clog2(WORD_SIZE)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_i,
  input  logic                                mode224_i,
  input  logic [NUM_WORDS*(ROT_W+WORD_SIZE)-1:0] state_i,
  input  logic [WORD_SIZE+ROT_W-1:0]          rnd_i,
  output logic [WORD_SIZE-1:0]                dout_o,
  output logic                                dout_valid_o,
  input  logic                                dout_ready_i,
  output logic                                dout_last_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int SW = WORD_SIZE + ROT_W;
  localparam int CW = (NUM_WORDS > 8) ? $clog2(NUM_WORDS) : 3;
  localparam logic [CW-1:0] LAST_FULL = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] LAST_224  = CW'(6);

  lw_sha_pkg::rd_state_t state_q;
  logic [CW-1:0]  cnt_q;
  logic           m224_q;
  logic           done_q;
  logic [SW-1:0]  slot_q [NUM_WORDS];
  logic [SW-1:0]  cur;
  logic [WORD_SIZE-1:0] plain;
  logic           busy;
  logic           last;
  logic           xfer;

  assign cur  = slot_q[cnt_q];
  assign busy = (state_q == lw_sha_pkg::ST_STREAM);
  assign last = busy & (cnt_q == (m224_q ? LAST_224 : LAST_FULL));
  assign xfer = busy & dout_ready_i;

  lw_sha_word_unmask #(
    .W  (WORD_SIZE),
    .RW (ROT_W)
  ) u_unmask (
    .word_i (cur[WORD_SIZE-1:0]),
    .rot_i  (cur[SW-1:WORD_SIZE]),
    .word_o (plain)
  );

  assign dout_o       = busy ? plain : '0;
  assign dout_valid_o = busy;
  assign dout_last_o  = last;
  assign busy_o       = busy;
  assign done_o       = done_q;

`ifndef LW_SHA_DIGEST_ZEROIZE_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= lw_sha_pkg::ST_IDLE;
      cnt_q   <= '0;
      m224_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++)
        slot_q[i] <= '0;
    end else begin
      done_q <= xfer & last;
      unique case (1'b1)
        !busy: begin
          if (load_i) begin
            state_q <= lw_sha_pkg::ST_STREAM;
            cnt_q   <= '0;
            m224_q  <= mode224_i;
            for (int i = 0; i < NUM_WORDS; i++)
              slot_q[i] <= state_i[i*SW +: SW];
          end
        end
        busy: begin
          if (xfer) begin
            if (last) begin
              state_q <= lw_sha_pkg::ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
`ifdef LW_SHA_DIGEST_ZEROIZE_EN
            slot_q[cnt_q] <= rnd_i;
            if (last)
              for (int i = 0; i < NUM_WORDS; i++)
                slot_q[i] <= rnd_i;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lw_sha_digest_reader.sv
// Self-checking bench for lw_sha_digest_reader (queue model + literals).
// Honours LW_SHA_DIGEST_ZEROIZE_EN for the slot-content checks.
module tb_lw_sha_digest_reader;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int RW = 5;
  localparam int SW = W + RW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_i;
  logic            mode224_i;
  logic [N*SW-1:0] state_i;
  logic [SW-1:0]   rnd_i;
  logic [W-1:0]    dout_o;
  logic            dout_valid_o;
  logic            dout_ready_i;
  logic            dout_last_o;
  logic            busy_o;
  logic            done_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
    32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17,
    32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  lw_sha_digest_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (load_i),
    .mode224_i    (mode224_i),
    .state_i      (state_i),
    .rnd_i        (rnd_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_last_o  (dout_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rol32(input logic [31:0] w, input int r);
    if (r == 0) return w;
    return (w << r) | (w >> (32 - r));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] w, input int r);
    if (r == 0) return w;
    return (w >> r) | (w << (32 - r));
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of plain words still owed to the sink.
  logic [31:0] exp_q [$];
  bit          m_busy;
  bit          m_done;
  bit          m_was;
  logic [SW-1:0] m_loaded [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0;
      m_done = 0;
    end else begin
      m_was  = m_busy;
      m_done = 0;
      if (m_was && dout_ready_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
      if (!m_was && load_i) begin
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
          m_loaded[i] = state_i[i*SW +: SW];
          if (i < (mode224_i ? 7 : 8))
            exp_q.push_back(rol32(m_loaded[i][31:0], int'(m_loaded[i][36:32])));
        end
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("valid", 64'(dout_valid_o), 64'(m_busy));
      check("busy", 64'(busy_o), 64'(m_busy));
      check("done", 64'(done_o), 64'(m_done));
      if (m_busy) begin
        check("dout", 64'(dout_o), 64'(exp_q[0]));
        check("last", 64'(dout_last_o), 64'(exp_q.size() == 1));
      end
    end
  end

  task automatic mk_state(input logic [31:0] w [8], output logic [N*SW-1:0] s);
    int r;
    for (int i = 0; i < N; i++) begin
      r = (i == 1) ? 0 : (i == 2) ? 31 : int'($urandom_range(0, 31));
      s[i*SW +: SW] = {5'(r), ror32(w[i], r)};
    end
  endtask

  task automatic do_load(input logic m, input logic [N*SW-1:0] s);
    @(negedge clk);
    load_i    = 1'b1;
    mode224_i = m;
    state_i   = s;
    @(negedge clk);
    load_i    = 1'b0;
  endtask

  // pat 0: ready high; pat 1: ready 1,0,0,1 repeating.
  task automatic run_stream(input int pat, input logic [31:0] last_lit,
                            input bit try_load);
    bit seen = 0;
    bit got  = 0;
    int k    = 0;
    logic [N*SW-1:0] junk;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done_o) begin
        got = 1;
        load_i = 1'b0;
      end else begin
        if (dout_valid_o && dout_last_o && !seen) begin
          seen = 1;
          check("last_word", 64'(dout_o), 64'(last_lit));
        end
        dout_ready_i = (pat == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
        k++;
        if (try_load) begin
          junk = {$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, $urandom};
          load_i    = 1'b1;
          mode224_i = 1'b1;
          state_i   = junk;
        end
        @(negedge clk);
      end
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
    dout_ready_i = 1'b0;
  endtask

  task automatic check_slots(input logic [SW-1:0] r, input bit use_rnd);
    for (int i = 0; i < N; i++)
      check("slot", 64'(dut.slot_q[i]), 64'(use_rnd ? r : m_loaded[i]));
  endtask

  logic [N*SW-1:0] s;

  initial begin
    rst_n = 1'b0;
    load_i = 1'b0;
    mode224_i = 1'b0;
    state_i = '0;
    rnd_i = '0;
    dout_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(dout_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_last", 64'(dout_last_o), 64'd0);
    check("rst_dout", 64'(dout_o), 64'd0);
    rst_n = 1'b1;
    chk_en = 1;

    // First word literal from slot0 = {5, 3B504F33}
    mk_state(iv256, s);
    s[SW-1:0] = {5'd5, 32'h3B504F33};
    dout_ready_i = 1'b1;
    do_load(1'b0, s);
    check("first_word", 64'(dout_o), 64'h6a09e667);
    check("first_valid", 64'(dout_valid_o), 64'd1);
    run_stream(0, 32'h5be0cd19, 0);

    // Full SHA-256 readout with loads attempted mid-stream
    mk_state(iv256, s);
    do_load(1'b0, s);
    run_stream(0, 32'h5be0cd19, 1);
    repeat (2) @(negedge clk);

    // SHA-224: seven words, slot 7 never offered
    mk_state(iv224, s);
    do_load(1'b1, s);
    run_stream(0, 32'h64f98fa7, 0);

    // Stalled sink
    mk_state(iv256, s);
    do_load(1'b0, s);
    run_stream(1, 32'h5be0cd19, 0);

    // Reset after the third transfer
    mk_state(iv256, s);
    dout_ready_i = 1'b1;
    do_load(1'b0, s);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dout_valid_o), 64'd0);
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    check("mid_rst_last", 64'(dout_last_o), 64'd0);
    check("mid_rst_dout", 64'(dout_o), 64'd0);
    for (int i = 0; i < N; i++)
      check("mid_rst_slot", 64'(dut.slot_q[i]), 64'd0);
    dout_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mk_state(iv256, s);
    do_load(1'b0, s);
    check("restart_word", 64'(dout_o), 64'h6a09e667);
    run_stream(0, 32'h5be0cd19, 0);

    // Slot contents after drain
    rnd_i = 37'h1F_FFFFFFFF;
    mk_state(iv256, s);
    do_load(1'b0, s);
    run_stream(0, 32'h5be0cd19, 0);
`ifdef LW_SHA_DIGEST_ZEROIZE_EN
    check_slots(rnd_i, 1);
`else
    check_slots(rnd_i, 0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
